// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// memory depth and header size.
package imem_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int HDR_BYTES  = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port and core status.
// The loader sits on the slave side; the byte source and memory are on the master side.
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, we, waddr, wdata, cpu_hold, done, err
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes little-endian into 32-bit words and keeps a running XOR.
// word_vld_o pulses the cycle after the lane-3 byte; word_o holds between pulses.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        lane_last_o,
  output logic        word_vld_o,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] word_q, word_d;
  logic        word_vld_q, word_vld_d;
  logic [7:0]  csum_q, csum_d;

  always_comb begin
    lane_d     = lane_q;
    asm_d      = asm_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    csum_d     = csum_q;
    if (clear_i) begin
      lane_d = '0;
      asm_d  = '0;
      csum_d = '0;
    end else if (byte_vld_i) begin
      csum_d = csum_q ^ byte_dat_i;
      lane_d = lane_q + 2'd1;
      // Lanes 0..2 are staged so the next word can start filling during the write cycle.
      unique case (lane_q)
        2'd0:    asm_d[7:0]   = byte_dat_i;
        2'd1:    asm_d[15:8]  = byte_dat_i;
        2'd2:    asm_d[23:16] = byte_dat_i;
        default: begin
          word_d     = {byte_dat_i, asm_q};
          word_vld_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= '0;
      asm_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      csum_q     <= '0;
    end else begin
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      csum_q     <= csum_d;
    end
  end

  assign lane_last_o = (lane_q == 2'd3);
  assign word_vld_o  = word_vld_q;
  assign word_o      = word_q;
  assign csum_o      = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header (word count), payload words written to imem, XOR checksum,
// then releases the core on success or keeps it held on failure.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  state_t             state_q, state_d;
  logic [0:0]         hdr_q, hdr_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   widx_q, widx_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [CNT_W-1:0]   n_full;
  logic               xfer;
  logic               pk_clear, pk_vld, pk_lane_last, pk_word_vld;
  logic [31:0]        pk_word;
  logic [7:0]         pk_csum;

  assign xfer   = bus.byte_valid && bus.byte_ready;
  assign n_full = CNT_W'({bus.byte_data, n_q[7:0]});

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    n_d      = n_q;
    widx_d   = widx_q;
    waddr_d  = waddr_q;
    pk_clear = 1'b0;
    pk_vld   = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d  = HDR;
          hdr_d    = '0;
          widx_d   = '0;
          pk_clear = 1'b1;
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdr_q == 1'(HDR_BYTES - 1)) begin
            n_d = n_full;
            if (32'(n_full) > 32'(DEPTH))  state_d = ERR;
            else if (n_full == '0)         state_d = CSUM;
            else                           state_d = DATA;
          end else begin
            n_d[7:0] = bus.byte_data;
            hdr_d    = hdr_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          pk_vld = 1'b1;
          // Address is latched with the word so it lines up with the packer's write pulse.
          if (pk_lane_last) begin
            waddr_d = 32'(widx_q) << 2;
            widx_d  = widx_q + 1'b1;
            if (widx_q == n_q - 1'b1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) state_d = (bus.byte_data == pk_csum) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      n_q     <= '0;
      widx_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      waddr_q <= waddr_d;
    end
  end

  imem_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (pk_clear),
    .byte_vld_i  (pk_vld),
    .byte_dat_i  (bus.byte_data),
    .lane_last_o (pk_lane_last),
    .word_vld_o  (pk_word_vld),
    .word_o      (pk_word),
    .csum_o      (pk_csum)
  );

  assign bus.byte_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign bus.cpu_hold   = bus.byte_ready || (state_q == ERR);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = (state_q == ERR);
  assign bus.we         = pk_word_vld;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a queue-based image model predicts writes and
// final status; a negedge monitor checks every write pulse against it.
module tb_imem_loader;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bus();
  imem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  int drops = 0;
  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] log_addr[$], log_data[$];
  logic        exp_done, exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Image model: word count from the header, payload words at 4*k, XOR of payload only.
  task automatic model();
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({stim[1], stim[0]});
    if (n > 256) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = {stim[2+4*k+3], stim[2+4*k+2], stim[2+4*k+1], stim[2+4*k]};
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_addr.push_back(32'(k) * 4);
      exp_data.push_back(w);
    end
    if (stim[2+4*n] == x) exp_done = 1'b1;
    else                  exp_err  = 1'b1;
  endtask

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      log_addr.push_back(bus.waddr);
      log_data.push_back(bus.wdata);
      if (exp_addr.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        check("waddr", bus.waddr, exp_addr.pop_front());
        check("wdata", bus.wdata, exp_data.pop_front());
      end
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_session(input string tag, input bit burst);
    int n;
    model();
    log_addr.delete();
    log_data.delete();
    drops = 0;
    n = int'({stim[1], stim[0]});
    do_start();
    check({tag, "_hold_on_start"}, 32'(bus.cpu_hold), 32'd1);
    for (int i = 0; i < stim.size(); i++) begin
      if (!burst && (i % 3 == 1)) begin
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      if (burst && i > 2 && i < 2 + 4*n && bus.byte_ready !== 1'b1) drops++;
      send_byte(stim[i]);
    end
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
    check({tag, "_done"},     32'(bus.done),     32'(exp_done));
    check({tag, "_err"},      32'(bus.err),      32'(exp_err));
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(exp_err));
    check({tag, "_ready"},    32'(bus.byte_ready), 32'd0);
  endtask

  task automatic load_small(input logic [7:0] cs);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, cs};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"},    32'(bus.we),         32'd0);
    check({tag, "_waddr"}, bus.waddr,           32'd0);
    check({tag, "_wdata"}, bus.wdata,           32'd0);
    check({tag, "_hold"},  32'(bus.cpu_hold),   32'd0);
    check({tag, "_done"},  32'(bus.done),       32'd0);
    check({tag, "_err"},   32'(bus.err),        32'd0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Payload XOR: 13^93^10 = 0x90, so 0x90 is the good checksum.
    load_small(8'h90);
    run_session("img_good", 1'b0);
    check("img_good_nwr",  32'(log_addr.size()), 32'd2);
    check("img_good_a0",   log_addr[0], 32'h0000_0000);
    check("img_good_d0",   log_data[0], 32'h0000_0013);
    check("img_good_a1",   log_addr[1], 32'h0000_0004);
    check("img_good_d1",   log_data[1], 32'h0010_0093);
    check("img_good_lit_done", 32'(bus.done), 32'd1);

    load_small(8'h80);
    run_session("img_cs80", 1'b0);
    check("img_cs80_nwr", 32'(log_addr.size()), 32'd2);
    check("img_cs80_lit_err", 32'(bus.err), 32'd1);

    load_small(8'h81);
    run_session("img_cs81", 1'b0);
    check("img_cs81_lit_hold", 32'(bus.cpu_hold), 32'd1);

    stim = '{8'h01, 8'h01};
    run_session("n257", 1'b0);
    check("n257_nwr", 32'(log_addr.size()), 32'd0);
    check("n257_lit_err", 32'(bus.err), 32'd1);

    stim = '{8'h00, 8'h00, 8'h00};
    run_session("n0_good", 1'b0);
    check("n0_good_lit_done", 32'(bus.done), 32'd1);
    stim = '{8'h00, 8'h00, 8'h5A};
    run_session("n0_bad", 1'b0);
    check("n0_bad_lit_err", 32'(bus.err), 32'd1);

    begin
      logic [7:0] x;
      x = 8'h00;
      stim = '{8'h00, 8'h01};
      for (int i = 0; i < 1024; i++) begin
        stim.push_back(8'($urandom_range(0, 255)));
        x = x ^ stim[stim.size()-1];
      end
      stim.push_back(x);
    end
    run_session("burst", 1'b1);
    check("burst_nwr",   32'(log_addr.size()), 32'd256);
    check("burst_last",  log_addr[255], 32'h0000_03FC);
    check("burst_drops", 32'(drops), 32'd0);
    check("burst_lit_done", 32'(bus.done), 32'd1);

    load_small(8'h90);
    model();
    log_addr.delete();
    log_data.delete();
    do_start();
    for (int i = 0; i < 9; i++) send_byte(stim[i]);
    check("midrst_wr_before", 32'(log_addr.size()), 32'd1);
    #2 rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_addr.delete();
    exp_data.delete();
    repeat (3) @(negedge clk);
    check("midrst_no_wr", 32'(log_addr.size()), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    run_session("after_rst", 1'b0);
    check("after_rst_a0", log_addr[0], 32'h0000_0000);
    check("after_rst_nwr", 32'(log_addr.size()), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
